setup_ctrl: RTL and testbench

// - Configuration sequencer for the lock. When operacional raises setup_on, walks the user through
//   six fields in fixed order: bip enable, bip time, auto-lock time, master password, user 1, user 2.
// - Validates keypad entries and keeps a working copy and a committed copy of the setup.
// - On completion, presents the new setup on data_setup_new with a 1-cycle data_setup_ok pulse.

---
 rtl/fechadura_pkg.sv | 73 +++++++
 rtl/setup_ctrl_if.sv | 25 ++
 rtl/setup_timeout.sv | 38 +++
 rtl/setup_ctrl.sv | 163 ++++++++++++++++
 tb/tb_setup_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fechadura_pkg.sv
// Shared types and constants for the lock: keypad entry packs, setup record,
// display pack and the setup sequencer state encoding.
package fechadura_pkg;

  localparam int N_DIG = 20;
  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_EMPTY = 4'hF;

  typedef logic [N_DIG-1:0][3:0] senhaPac_t;
  typedef logic [5:0][3:0]       bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranc_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
  } setupPac_t;

  // Field states are numbered 1..6 so the encoding doubles as the displayed field index
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_F_BIP    = 3'd1,
    ST_F_BIPT   = 3'd2,
    ST_F_TRAV   = 3'd3,
    ST_F_MASTER = 3'd4,
    ST_F_USR1   = 3'd5,
    ST_F_USR2   = 3'd6,
    ST_COMMIT   = 3'd7
  } setup_state_t;

  typedef struct packed {
    logic       well_formed;
    logic [4:0] len;
  } entry_info_t;

  localparam senhaPac_t SENHA_EMPTY = {N_DIG{KEY_EMPTY}};
  localparam senhaPac_t SENHA_DEF   = {{(N_DIG-4){KEY_EMPTY}}, 4'h4, 4'h3, 4'h2, 4'h1};

  localparam setupPac_t SETUP_DEF = '{
    bip_status:     1'b1,
    bip_time:       7'd5,
    tranc_aut_time: 7'd5,
    senha_master:   SENHA_DEF,
    senha_1:        SENHA_EMPTY,
    senha_2:        SENHA_EMPTY
  };

  // Well formed = decimal digits packed from slot 0, followed only by empty slots
  function automatic entry_info_t scan_entry(input senhaPac_t d);
    entry_info_t r;
    logic        seen_empty;
    r.well_formed = 1'b1;
    r.len         = 5'd0;
    seen_empty    = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (d[i] == KEY_EMPTY) begin
        seen_empty = 1'b1;
      end else if (seen_empty || d[i] > 4'd9) begin
        r.well_formed = 1'b0;
      end else begin
        r.len = r.len + 5'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/setup_ctrl_if.sv
// Keypad-in / setup-out bundle between operacional, keypad, display and setup_ctrl.
interface setup_ctrl_if;
  import fechadura_pkg::*;

  logic      setup_on;
  senhaPac_t digitos_value;
  logic      digitos_valid;
  setupPac_t data_setup_new;
  logic      data_setup_ok;
  bcdPac_t   bcd_pac;
  logic      teclado_en;
  logic      display_en;
  logic      err;

  modport master (
    output setup_on, digitos_value, digitos_valid,
    input  data_setup_new, data_setup_ok, bcd_pac, teclado_en, display_en, err
  );

  modport slave (
    input  setup_on, digitos_value, digitos_valid,
    output data_setup_new, data_setup_ok, bcd_pac, teclado_en, display_en, err
  );

endinterface

// File: rtl/setup_timeout.sv
// Inactivity timer: prescaler to seconds, one-cycle expiry pulse after TIMEOUT_S seconds.
module setup_timeout #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  logic [PW-1:0] tick_reg;
  logic [SW-1:0] sec_reg;
  logic          sec_wrap;

  assign sec_wrap = (tick_reg == PW'(CLK_HZ - 1));
  assign expired  = en && !clr && sec_wrap && (sec_reg == SW'(TIMEOUT_S - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_reg <= '0;
      sec_reg  <= '0;
    end else if (!en || clr || expired) begin
      tick_reg <= '0;
      sec_reg  <= '0;
    end else if (sec_wrap) begin
      tick_reg <= '0;
      sec_reg  <= sec_reg + SW'(1);
    end else begin
      tick_reg <= tick_reg + PW'(1);
    end
  end

endmodule

// File: rtl/setup_ctrl.sv
// Lock setup sequencer: six keypad-driven fields, working/committed setup copies.
// Optional inactivity timeout enabled by defining SETUP_TIMEOUT_EN.
module setup_ctrl
  import fechadura_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int T_MIN     = 5,
  parameter int T_MAX     = 60,
  parameter int PWD_MIN   = 4,
  parameter int PWD_MAX   = 12,
  parameter int TIMEOUT_S = 30
) (
  input  logic         clk,
  input  logic         rst,
  setup_ctrl_if.slave  bus
);

  setup_state_t state_reg, state_next;
  setupPac_t    working_reg, working_next;
  setupPac_t    committed_reg, committed_next;
  logic         setup_on_d_reg;

  logic         in_field, start, timeout_expired, err_c, accept;
  entry_info_t  entry;
  logic [6:0]   entry_val;
  logic [3:0]   d0;
  logic         keep, bip_ok, time_ok, pwd_ok, usr_clear;
  senhaPac_t    pwd_shown;
  bcdPac_t      bcd_c;

  assign in_field = (state_reg != ST_IDLE) && (state_reg != ST_COMMIT);
  assign start    = bus.setup_on && !setup_on_d_reg;

`ifdef SETUP_TIMEOUT_EN
  // Every field change is caused by a strobe, so clearing on strobes covers state changes too
  setup_timeout #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_S (TIMEOUT_S)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (in_field),
    .clr     (bus.digitos_valid),
    .expired (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{32'(CLK_HZ), 32'(TIMEOUT_S)};
  assign timeout_expired    = 1'b0;
`endif

  assign entry     = scan_entry(bus.digitos_value);
  assign d0        = bus.digitos_value[0];
  assign entry_val = (entry.len == 5'd1) ? {3'b000, d0}
                                         : {3'b000, d0} * 7'd10 + {3'b000, bus.digitos_value[1]};
  assign keep      = (d0 == KEY_STAR);
  assign bip_ok    = entry.well_formed && (entry.len == 5'd1) && (d0 <= 4'd1);
  assign time_ok   = entry.well_formed && ((entry.len == 5'd1) || (entry.len == 5'd2)) &&
                     (entry_val >= 7'(T_MIN)) && (entry_val <= 7'(T_MAX));
  assign pwd_ok    = entry.well_formed && (entry.len >= 5'(PWD_MIN)) && (entry.len <= 5'(PWD_MAX));
  assign usr_clear = entry.well_formed && (entry.len == 5'd1) && (d0 == 4'd0);

  always_comb begin
    state_next     = state_reg;
    working_next   = working_reg;
    committed_next = committed_reg;
    err_c          = 1'b0;
    accept         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_F_BIP;
          working_next = committed_reg;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default: begin
        // Abort has priority over both timeout and a simultaneous entry
        if (!bus.setup_on) begin
          state_next = ST_IDLE;
        end else if (timeout_expired) begin
          state_next = ST_IDLE;
          err_c      = 1'b1;
        end else if (bus.digitos_valid) begin
          accept = keep;
          case (state_reg)
            ST_F_BIP: if (!keep && bip_ok) begin
              accept                  = 1'b1;
              working_next.bip_status = d0[0];
            end
            ST_F_BIPT: if (!keep && time_ok) begin
              accept                = 1'b1;
              working_next.bip_time = entry_val;
            end
            ST_F_TRAV: if (!keep && time_ok) begin
              accept                      = 1'b1;
              working_next.tranc_aut_time = entry_val;
            end
            ST_F_MASTER: if (!keep && pwd_ok) begin
              accept                    = 1'b1;
              working_next.senha_master = bus.digitos_value;
            end
            ST_F_USR1: if (!keep && (usr_clear || pwd_ok)) begin
              accept               = 1'b1;
              working_next.senha_1 = usr_clear ? SENHA_EMPTY : bus.digitos_value;
            end
            ST_F_USR2: if (!keep && (usr_clear || pwd_ok)) begin
              accept               = 1'b1;
              working_next.senha_2 = usr_clear ? SENHA_EMPTY : bus.digitos_value;
            end
            default: ;
          endcase
          if (accept) state_next = setup_state_t'(state_reg + 3'd1);
          else        err_c      = 1'b1;
        end
      end
    endcase
    if (state_next == ST_COMMIT) committed_next = working_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      working_reg    <= SETUP_DEF;
      committed_reg  <= SETUP_DEF;
      setup_on_d_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      working_reg    <= working_next;
      committed_reg  <= committed_next;
      setup_on_d_reg <= bus.setup_on;
    end
  end

  always_comb begin
    case (state_reg)
      ST_F_USR1: pwd_shown = working_reg.senha_1;
      ST_F_USR2: pwd_shown = working_reg.senha_2;
      default:   pwd_shown = working_reg.senha_master;
    endcase
  end

  always_comb begin
    bcd_c = '1;
    case (state_reg)
      ST_F_BIP:  bcd_c[0]             = {3'b000, working_reg.bip_status};
      ST_F_BIPT: {bcd_c[1], bcd_c[0]} = to_bcd2(working_reg.bip_time);
      ST_F_TRAV: {bcd_c[1], bcd_c[0]} = to_bcd2(working_reg.tranc_aut_time);
      ST_F_MASTER, ST_F_USR1, ST_F_USR2:
        {bcd_c[1], bcd_c[0]} = to_bcd2({2'b00, scan_entry(pwd_shown).len});
      default: ;
    endcase
    if (in_field) bcd_c[5] = {1'b0, state_reg};
  end

  assign bus.data_setup_new = committed_reg;
  assign bus.data_setup_ok  = (state_reg == ST_COMMIT);
  assign bus.bcd_pac        = bcd_c;
  assign bus.teclado_en     = in_field;
  assign bus.display_en     = in_field;
  assign bus.err            = err_c;

endmodule

// File: tb/tb_setup_ctrl.sv
// Scoreboard bench for setup_ctrl: per-entry err/field expectations and commit records.
module tb_setup_ctrl;
  import fechadura_pkg::*;

  typedef struct {
    logic       err;
    logic [3:0] field;
  } step_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  setup_ctrl_if bus();

  setup_ctrl #(
    .CLK_HZ    (10),
    .TIMEOUT_S (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  step_exp_t step_q[$];
  setupPac_t commit_q[$];
  int total = 0;
  int bad = 0;
  int ok_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic senhaPac_t ent(input string s);
    senhaPac_t r;
    byte       c;
    r = '1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'd48 && c <= 8'd57) r[i] = 4'(c - 8'd48);
      else if (c == 8'd42)          r[i] = 4'hA;
      else                          r[i] = 4'hB;
    end
    return r;
  endfunction

  function automatic bcdPac_t exp_bcd(input int f, input int v, input bit one_digit);
    bcdPac_t r;
    r    = '1;
    r[5] = 4'(f);
    if (one_digit) r[0] = 4'(v);
    else begin
      r[1] = 4'(v / 10);
      r[0] = 4'(v % 10);
    end
    return r;
  endfunction

  function automatic setupPac_t mk_setup(input bit b, input int bt, input int tt,
                                         input string m, input string u1, input string u2);
    setupPac_t r;
    r.bip_status     = b;
    r.bip_time       = 7'(bt);
    r.tranc_aut_time = 7'(tt);
    r.senha_master   = ent(m);
    r.senha_1        = ent(u1);
    r.senha_2        = ent(u2);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s, input bit exp_err, input int exp_field, input bit abort);
    step_exp_t e;
    logic      obs_err;
    tick();
    step_q.push_back('{exp_err, 4'(exp_field)});
    bus.digitos_value = ent(s);
    bus.digitos_valid = 1'b1;
    if (abort) bus.setup_on = 1'b0;
    @(negedge clk);
    obs_err = bus.err;
    tick();
    bus.digitos_valid = 1'b0;
    bus.digitos_value = '1;
    @(negedge clk);
    e = step_q.pop_front();
    chk({"err ", s}, obs_err, e.err);
    chk({"field ", s}, bus.bcd_pac[5], e.field);
    $display("entry '%s' err=%0b field=%0h", s, obs_err, bus.bcd_pac[5]);
  endtask

  always @(negedge clk) begin
    if (rst && bus.data_setup_ok) begin
      ok_cnt++;
      if (commit_q.size() == 0) begin
        chk("ok_spurious", bus.data_setup_ok, 1'b0);
      end else begin
        chk("commit_data", bus.data_setup_new, commit_q.pop_front());
        $display("commit %0d observed", ok_cnt);
      end
    end
  end

  initial begin
    setupPac_t def_s, exp1, exp2;
    bcdPac_t   blank;
    int        n;
    blank = '1;
    def_s = mk_setup(1'b1, 5, 5, "1234", "", "");
    exp1  = mk_setup(1'b0, 15, 30, "9876", "1111", "");
    exp2  = mk_setup(1'b0, 60, 5, "9876", "", "4321");

    rst               = 1'b0;
    bus.setup_on      = 1'b0;
    bus.digitos_valid = 1'b0;
    bus.digitos_value = '1;
    #12;
    chk("rst_ok", bus.data_setup_ok, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_kbd", bus.teclado_en, 1'b0);
    chk("rst_disp", bus.display_en, 1'b0);
    chk("rst_bcd", bus.bcd_pac, blank);
    chk("rst_new", bus.data_setup_new, def_s);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // session 1: full walk with rejected entries along the way
    bus.setup_on = 1'b1;
    tick();
    chk("s1_kbd", bus.teclado_en, 1'b1);
    chk("s1_disp", bus.display_en, 1'b1);
    chk("s1_bcd_bip", bus.bcd_pac, exp_bcd(1, 1, 1'b1));
    send("2", 1'b1, 1, 1'b0);
    send("0", 1'b0, 2, 1'b0);
    chk("s1_bcd_bipt", bus.bcd_pac, exp_bcd(2, 5, 1'b0));
    send("4", 1'b1, 2, 1'b0);
    send("61", 1'b1, 2, 1'b0);
    send("2", 1'b1, 2, 1'b0);
    send("15", 1'b0, 3, 1'b0);
    chk("s1_bcd_trav", bus.bcd_pac, exp_bcd(3, 5, 1'b0));
    send("30", 1'b0, 4, 1'b0);
    chk("s1_bcd_master", bus.bcd_pac, exp_bcd(4, 4, 1'b0));
    send("123", 1'b1, 4, 1'b0);
    send("1234567890123", 1'b1, 4, 1'b0);
    send("9876", 1'b0, 5, 1'b0);
    send("1111", 1'b0, 6, 1'b0);
    chk("s1_bcd_usr2", bus.bcd_pac, exp_bcd(6, 0, 1'b0));
    commit_q.push_back(exp1);
    send("0", 1'b0, 15, 1'b0);

    // setup_on stays high: no new session
    repeat (4) tick();
    chk("hold_kbd", bus.teclado_en, 1'b0);
    chk("hold_new", bus.data_setup_new, exp1);
    chk("ok_count1", ok_cnt, 1);

    // session 2: bounds, star keep, user clear, bad code after slot 0
    bus.setup_on = 1'b0;
    tick();
    bus.setup_on = 1'b1;
    tick();
    chk("s2_bcd_bip", bus.bcd_pac, exp_bcd(1, 0, 1'b1));
    send("*", 1'b0, 2, 1'b0);
    send("4", 1'b1, 2, 1'b0);
    send("61", 1'b1, 2, 1'b0);
    send("2", 1'b1, 2, 1'b0);
    send("60", 1'b0, 3, 1'b0);
    send("5", 1'b0, 4, 1'b0);
    send("*", 1'b0, 5, 1'b0);
    send("0", 1'b0, 6, 1'b0);
    send("1b34", 1'b1, 6, 1'b0);
    commit_q.push_back(exp2);
    send("4321", 1'b0, 15, 1'b0);

    // session 3: abort in F_MASTER together with a strobe
    bus.setup_on = 1'b0;
    tick();
    bus.setup_on = 1'b1;
    tick();
    send("*", 1'b0, 2, 1'b0);
    send("*", 1'b0, 3, 1'b0);
    send("*", 1'b0, 4, 1'b0);
    send("1111", 1'b0, 15, 1'b1);
    chk("abort_kbd", bus.teclado_en, 1'b0);
    tick();
    bus.setup_on = 1'b1;
    tick();
    chk("s4_bcd_bip", bus.bcd_pac, exp_bcd(1, 0, 1'b1));
    send("*", 1'b0, 2, 1'b0);
    chk("s4_bcd_bipt", bus.bcd_pac, exp_bcd(2, 60, 1'b0));
    chk("abort_new", bus.data_setup_new, exp2);
    send("*", 1'b0, 3, 1'b0);

    // asynchronous reset in F_TRAV
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mrst_kbd", bus.teclado_en, 1'b0);
    chk("mrst_disp", bus.display_en, 1'b0);
    chk("mrst_bcd", bus.bcd_pac, blank);
    chk("mrst_ok", bus.data_setup_ok, 1'b0);
    chk("mrst_new", bus.data_setup_new, def_s);
    bus.setup_on = 1'b0;
    tick();
    rst = 1'b1;
    tick();

`ifdef SETUP_TIMEOUT_EN
    bus.setup_on = 1'b1;
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.err) begin
        n = i;
        break;
      end
    end
    chk("timeout_cycles", n, 20);
    tick();
    chk("timeout_idle", bus.teclado_en, 1'b0);
    $display("timeout err after %0d cycles", n);
    bus.setup_on = 1'b0;
    tick();
`else
    n = 0;
`endif

    repeat (3) tick();
    chk("ok_count", ok_cnt, 2);
    chk("commit_pending", commit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
